// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared types and constants for the load/store sequencer:
//            funct3 encodings, FSM state type, fault causes and the
//            request fault classifier.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // RV32 load funct3 encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // RV32 store funct3 encodings
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Access size field (funct3[1:0])
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Response cause codes
    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    // Stores only know SB/SH/SW; loads reject 011, 110 and 111.
    function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
        logic illegal;
        if (we) begin
            illegal = !((funct3 == SB) || (funct3 == SH) || (funct3 == SW));
        end else begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        return illegal;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic mis;
        case (funct3[1:0])
            SIZE_HALF: mis = offset[0];
            SIZE_WORD: mis = (offset != 2'b00);
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Illegal funct3 outranks misalignment.
    function automatic logic [1:0] fault_cause(input logic we, input logic [2:0] funct3,
                                               input logic [1:0] offset);
        logic [1:0] cause;
        if (funct3_illegal(we, funct3)) begin
            cause = CAUSE_ILLEGAL;
        end else if (addr_misaligned(funct3, offset)) begin
            cause = CAUSE_MISALIGN;
        end else begin
            cause = CAUSE_NONE;
        end
        return cause;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_core_if / lsu_mem_if
// Brief    : Core-side request/response bundle and memory-side port bundle
//            of the load/store sequencer. The core is master of
//            lsu_core_if; the sequencer is master of lsu_mem_if.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_core_if;
    import lsu_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  resp_cause;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, resp_cause
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, resp_cause
    );
endinterface

interface lsu_mem_if;
    import lsu_pkg::*;

    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_align
// Brief    : Combinational load extractor: selects the addressed byte or
//            halfword lane of a memory word and sign/zero-extends it.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  wire logic [2:0]  i_funct3,
    input  wire logic [1:0]  i_offset,
    input  wire logic [31:0] i_word,
    output logic      [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select followed by extension according to the load type
    always_comb begin
        w_byte = i_word[{i_offset, 3'b000} +: 8];
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
        o_data = '0;
        case (i_funct3)
            LB:      o_data = {{24{w_byte[7]}}, w_byte};
            LH:      o_data = {{16{w_half[15]}}, w_half};
            LW:      o_data = i_word;
            LBU:     o_data = {24'h000000, w_byte};
            LHU:     o_data = {16'h0000, w_half};
            default: o_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Brief    : Load/store sequencer between the core memory stage and a
//            single word-wide memory port. One access in flight, alignment
//            and funct3 checking, byte enables, store lane shifting and
//            load extraction with a single registered response pulse.
//            Optional macro LSU_MEM_TIMEOUT_EN adds an access timeout that
//            aborts REQ/WAIT after TIMEOUT_CYCLES cycles with cause 3.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_WIDTH       = 8
) (
    input  wire logic   clk,
    input  wire logic   reset,
    lsu_core_if.slave   core,
    lsu_mem_if.master   mem
);

    lsu_state_t  r_state;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic [1:0]  r_resp_cause;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;

    // Access context kept for the response phase
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_offset;

    logic [1:0]  w_offset;
    logic [1:0]  w_cause;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;
    logic        w_expire;

    // Fault classification, byte enables and lane-shifted store data for the incoming request
    always_comb begin
        w_offset = core.req_addr[1:0];
        w_cause  = fault_cause(core.req_we, core.req_funct3, w_offset);
        w_be     = 4'b0000;
        w_wdata  = '0;
        if (core.req_we) begin
            case (core.req_funct3[1:0])
                SIZE_BYTE: begin
                    w_be    = 4'b0001 << w_offset;
                    w_wdata = {24'h000000, core.req_wdata[7:0]} << {w_offset, 3'b000};
                end
                SIZE_HALF: begin
                    w_be    = 4'b0011 << w_offset;
                    w_wdata = {16'h0000, core.req_wdata[15:0]} << {w_offset, 3'b000};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = core.req_wdata;
                end
            endcase
        end
    end

    lsu_load_align u_load_align (
        .i_funct3 (r_funct3),
        .i_offset (r_offset),
        .i_word   (mem.mem_rdata),
        .o_data   (w_load_data)
    );

`ifdef LSU_MEM_TIMEOUT_EN
    logic [TO_WIDTH-1:0] r_to_cnt;

    // Counter sits at zero in IDLE/RESP so it starts from zero on every entry to REQ
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if ((r_state == REQ) || (r_state == WAIT)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    // Expiry is the cycle on which the count reaches TIMEOUT_CYCLES
    assign w_expire = ((r_state == REQ) || (r_state == WAIT)) &&
                      (r_to_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_to_cfg;

    assign w_expire        = 1'b0;
    assign w_unused_to_cfg = (TIMEOUT_CYCLES > (1 << TO_WIDTH));
`endif

    // Sequencer FSM with all core and memory outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_resp_cause <= CAUSE_NONE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= 4'b0000;
            r_mem_wdata  <= '0;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_offset     <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (core.req_valid) begin
                        r_we        <= core.req_we;
                        r_funct3    <= core.req_funct3;
                        r_offset    <= w_offset;
                        r_req_ready <= 1'b0;
                        if (w_cause != CAUSE_NONE) begin
                            // Faulted request: answer directly, no memory traffic
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_cause <= w_cause;
                            r_resp_rdata <= '0;
                        end else begin
                            r_state     <= REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= core.req_we;
                            r_mem_addr  <= {core.req_addr[31:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                        end
                    end
                end

                REQ: begin
                    if (w_expire) begin
                        r_state      <= RESP;
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_mem_be     <= 4'b0000;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_cause <= CAUSE_TIMEOUT;
                        r_resp_rdata <= '0;
                    end else if (mem.mem_gnt) begin
                        r_state   <= WAIT;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_mem_be  <= 4'b0000;
                    end
                end

                WAIT: begin
                    // A response on the expiry cycle still completes normally
                    if (mem.mem_rvalid) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_cause <= CAUSE_NONE;
                        r_resp_rdata <= r_we ? 32'h0 : w_load_data;
                    end else if (w_expire) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_cause <= CAUSE_TIMEOUT;
                        r_resp_rdata <= '0;
                    end
                end

                RESP: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                end

                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_mem_req   <= 1'b0;
                end
            endcase
        end
    end

    assign core.req_ready  = r_req_ready;
    assign core.resp_valid = r_resp_valid;
    assign core.resp_rdata = r_resp_rdata;
    assign core.resp_err   = r_resp_err;
    assign core.resp_cause = r_resp_cause;

    assign mem.mem_req     = r_mem_req;
    assign mem.mem_we      = r_mem_we;
    assign mem.mem_addr    = r_mem_addr;
    assign mem.mem_be      = r_mem_be;
    assign mem.mem_wdata   = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_ctrl
// Brief    : Self-checking bench for lsu_mem_ctrl: directed vector table,
//            randomized accesses against a byte-lane reference model, and
//            hand sequences for reset and timeout corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

    logic clk;
    logic reset;

    lsu_core_if core_bus ();
    lsu_mem_if  mem_bus ();

    lsu_mem_ctrl #(
        .TIMEOUT_CYCLES (10),
        .TO_WIDTH       (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .core  (core_bus.slave),
        .mem   (mem_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    typedef struct {
        bit          got;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  cause;
        bit          saw_req;
        logic [31:0] maddr;
        logic [3:0]  mbe;
        logic [31:0] mwdata;
        logic        mwe;
        bit          stable;
        bit          ready_low;
        bit          pulse_ok;
    } obs_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rword;
        int          gnt_dly;
        int          rv_dly;
        logic        err;
        logic [1:0]  cause;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] mwdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [1:0]  cause;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] mwdata;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: legality by encoding list, size in bytes, lanes moved byte by byte
    function automatic exp_t model(input logic we, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] rword);
        exp_t        e;
        int          off;
        int          size;
        bit          legal;
        logic [63:0] v;
        e     = '{default: '0};
        off   = int'(addr[1:0]);
        size  = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) begin
            e.err = 1'b1; e.cause = 2'd2;
        end else if ((off % size) != 0) begin
            e.err = 1'b1; e.cause = 2'd1;
        end else if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + size) begin
                    e.be[i] = 1'b1;
                    e.mwdata[8*i +: 8] = wdata[8*(i-off) +: 8];
                end
            end
        end else begin
            v = '0;
            for (int k = 0; k < size; k++) v[8*k +: 8] = rword[8*(off+k) +: 8];
            if (!f3[2] && size < 4 && v[8*size-1]) begin
                for (int b = 8*size; b < 32; b++) v[b] = 1'b1;
            end
            e.rdata = v[31:0];
        end
        return e;
    endfunction

    // Issue one request and play the memory: grant after gnt_dly stalled REQ cycles,
    // rvalid after rv_dly idle WAIT cycles (rv_dly < 0: never respond)
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rword,
                              input int gnt_dly, input int rv_dly, output obs_t o);
        int req_cyc;
        int wait_cyc;
        bit granted;
        bit rv_done;
        o = '{default: '0};
        o.stable    = 1'b1;
        o.ready_low = 1'b1;
        core_bus.req_valid  = 1'b1;
        core_bus.req_we     = we;
        core_bus.req_funct3 = f3;
        core_bus.req_addr   = addr;
        core_bus.req_wdata  = wdata;
        @(posedge clk); #1;
        core_bus.req_valid  = 1'b0;
        core_bus.req_we     = 1'($urandom);
        core_bus.req_funct3 = 3'($urandom);
        core_bus.req_addr   = $urandom;
        core_bus.req_wdata  = $urandom;
        req_cyc  = 0;
        wait_cyc = 0;
        granted  = 1'b0;
        rv_done  = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            if (core_bus.resp_valid === 1'b1) begin
                o.got   = 1'b1;
                o.lat   = e + 1;
                o.rdata = core_bus.resp_rdata;
                o.err   = core_bus.resp_err;
                o.cause = core_bus.resp_cause;
                break;
            end
            if (core_bus.req_ready !== 1'b0) o.ready_low = 1'b0;
            mem_bus.mem_gnt    = 1'b0;
            mem_bus.mem_rvalid = 1'b0;
            mem_bus.mem_rdata  = $urandom;
            if (granted) begin
                wait_cyc++;
                mem_bus.mem_gnt = 1'($urandom);
                if (!rv_done && rv_dly >= 0 && wait_cyc > rv_dly) begin
                    mem_bus.mem_rvalid = 1'b1;
                    mem_bus.mem_rdata  = rword;
                    rv_done = 1'b1;
                end
            end else if (mem_bus.mem_req === 1'b1) begin
                req_cyc++;
                if (!o.saw_req) begin
                    o.saw_req = 1'b1;
                    o.maddr   = mem_bus.mem_addr;
                    o.mbe     = mem_bus.mem_be;
                    o.mwdata  = mem_bus.mem_wdata;
                    o.mwe     = mem_bus.mem_we;
                end else if (mem_bus.mem_addr !== o.maddr || mem_bus.mem_be !== o.mbe ||
                             mem_bus.mem_wdata !== o.mwdata || mem_bus.mem_we !== o.mwe) begin
                    o.stable = 1'b0;
                end
                if (req_cyc > gnt_dly) begin
                    mem_bus.mem_gnt = 1'b1;
                    granted = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        mem_bus.mem_gnt    = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        if (o.got) begin
            @(posedge clk); #1;
            o.pulse_ok = (core_bus.resp_valid === 1'b0) && (core_bus.req_ready === 1'b1);
        end
    endtask

    task automatic check_access(input string tag, input logic we, input logic [31:0] addr,
                                input int gnt_dly, input int rv_dly, input exp_t e,
                                input obs_t o);
        chk({tag, " resp_seen"}, 32'(o.got), 32'd1);
        chk({tag, " resp_rdata"}, o.rdata, e.rdata);
        chk({tag, " resp_err"}, 32'(o.err), 32'(e.err));
        chk({tag, " resp_cause"}, 32'(o.cause), 32'(e.cause));
        chk({tag, " latency"}, 32'(o.lat), e.err ? 32'd2 : 32'(gnt_dly + rv_dly + 4));
        chk({tag, " ready_low"}, 32'(o.ready_low), 32'd1);
        chk({tag, " one_pulse"}, 32'(o.pulse_ok), 32'd1);
        if (e.err) begin
            chk({tag, " no_mem_req"}, 32'(o.saw_req), 32'd0);
        end else begin
            chk({tag, " mem_req"}, 32'(o.saw_req), 32'd1);
            chk({tag, " mem_addr"}, o.maddr, {addr[31:2], 2'b00});
            chk({tag, " mem_be"}, 32'(o.mbe), 32'(e.be));
            chk({tag, " mem_we"}, 32'(o.mwe), 32'(we));
            chk({tag, " req_stable"}, 32'(o.stable), 32'd1);
            if (we) chk({tag, " mem_wdata"}, o.mwdata, e.mwdata);
        end
    endtask

    vec_t tbl[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t        o;
        exp_t        e;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rword;
        int          gd;
        int          rd;
        bit          seen;

        n_cmp = 0;
        n_err = 0;

        //           we    f3      addr          wdata         rword        gd rd err  cause  rdata         be       mwdata
        tbl[0]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,        32'h8012_3456, 0, 0, 1'b0, 2'd0, 32'hFFFF_FF80, 4'b0000, 32'h0};
        tbl[1]  = '{1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h1111_1111, 0, 0, 1'b0, 2'd0, 32'h0,        4'b1100, 32'hBEEF_0000};
        tbl[2]  = '{1'b0, 3'b101, 32'h0000_3001, 32'h0,        32'h0,        0, 0, 1'b1, 2'd1, 32'h0,        4'b0000, 32'h0};
        tbl[3]  = '{1'b0, 3'b011, 32'h0000_4000, 32'h0,        32'h0,        0, 0, 1'b1, 2'd2, 32'h0,        4'b0000, 32'h0};
        tbl[4]  = '{1'b0, 3'b010, 32'h0000_5000, 32'h0,        32'hDEAD_BEEF, 5, 0, 1'b0, 2'd0, 32'hDEAD_BEEF, 4'b0000, 32'h0};
        tbl[5]  = '{1'b0, 3'b100, 32'h0000_6002, 32'h0,        32'h11A2_3344, 0, 1, 1'b0, 2'd0, 32'h0000_00A2, 4'b0000, 32'h0};
        tbl[6]  = '{1'b0, 3'b001, 32'h0000_7002, 32'h0,        32'h8001_1234, 1, 0, 1'b0, 2'd0, 32'hFFFF_8001, 4'b0000, 32'h0};
        tbl[7]  = '{1'b1, 3'b000, 32'h0000_8001, 32'h1234_56AB, 32'h0,        0, 2, 1'b0, 2'd0, 32'h0,        4'b0010, 32'h0000_AB00};
        tbl[8]  = '{1'b1, 3'b010, 32'h0000_9002, 32'h0,        32'h0,        0, 0, 1'b1, 2'd1, 32'h0,        4'b0000, 32'h0};
        tbl[9]  = '{1'b1, 3'b101, 32'h0000_A001, 32'h0,        32'h0,        0, 0, 1'b1, 2'd2, 32'h0,        4'b0000, 32'h0};
        tbl[10] = '{1'b0, 3'b101, 32'h0000_B002, 32'h0,        32'h8001_1234, 0, 0, 1'b0, 2'd0, 32'h0000_8001, 4'b0000, 32'h0};
        tbl[11] = '{1'b1, 3'b010, 32'h0000_C000, 32'hCAFE_F00D, 32'h0,        2, 3, 1'b0, 2'd0, 32'h0,        4'b1111, 32'hCAFE_F00D};

        core_bus.req_valid  = 1'b0;
        core_bus.req_we     = 1'b0;
        core_bus.req_funct3 = 3'b000;
        core_bus.req_addr   = '0;
        core_bus.req_wdata  = '0;
        mem_bus.mem_gnt     = 1'b0;
        mem_bus.mem_rvalid  = 1'b0;
        mem_bus.mem_rdata   = '0;

        // Reset values
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst req_ready", 32'(core_bus.req_ready), 32'd1);
        chk("rst resp_valid", 32'(core_bus.resp_valid), 32'd0);
        chk("rst resp_err", 32'(core_bus.resp_err), 32'd0);
        chk("rst resp_cause", 32'(core_bus.resp_cause), 32'd0);
        chk("rst resp_rdata", core_bus.resp_rdata, 32'd0);
        chk("rst mem_req", 32'(mem_bus.mem_req), 32'd0);
        chk("rst mem_we", 32'(mem_bus.mem_we), 32'd0);
        chk("rst mem_be", 32'(mem_bus.mem_be), 32'd0);
        chk("rst mem_addr", mem_bus.mem_addr, 32'd0);
        chk("rst mem_wdata", mem_bus.mem_wdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            e = '{tbl[i].err, tbl[i].cause, tbl[i].rdata, tbl[i].be, tbl[i].mwdata};
            run_access(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].rword,
                       tbl[i].gnt_dly, tbl[i].rv_dly, o);
            check_access($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr,
                         tbl[i].gnt_dly, tbl[i].rv_dly, e, o);
        end

        // Randomized accesses against the reference model
        for (int i = 0; i < 40; i++) begin
            we    = 1'($urandom);
            f3    = 3'($urandom);
            addr  = $urandom;
            wdata = $urandom;
            rword = $urandom;
            gd    = int'($urandom_range(0, 3));
            rd    = int'($urandom_range(0, 3));
            e     = model(we, f3, addr, wdata, rword);
            run_access(we, f3, addr, wdata, rword, gd, rd, o);
            check_access($sformatf("rnd%0d", i), we, addr, gd, rd, e, o);
        end

        // Reset while waiting for the memory response, then a late rvalid
        core_bus.req_valid  = 1'b1;
        core_bus.req_we     = 1'b0;
        core_bus.req_funct3 = 3'b010;
        core_bus.req_addr   = 32'h0000_0040;
        @(posedge clk); #1;
        core_bus.req_valid = 1'b0;
        chk("rstwait mem_req_in_req", 32'(mem_bus.mem_req), 32'd1);
        mem_bus.mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_gnt = 1'b0;
        chk("rstwait mem_req_in_wait", 32'(mem_bus.mem_req), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rstwait req_ready", 32'(core_bus.req_ready), 32'd1);
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'h1234_5678;
        @(posedge clk); #1;
        mem_bus.mem_rvalid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (core_bus.resp_valid !== 1'b0 || mem_bus.mem_req !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("rstwait no_resp", 32'(seen), 32'd0);

        // Reset while the request is still being presented
        core_bus.req_valid  = 1'b1;
        core_bus.req_we     = 1'b1;
        core_bus.req_funct3 = 3'b010;
        core_bus.req_addr   = 32'h0000_0080;
        @(posedge clk); #1;
        core_bus.req_valid = 1'b0;
        chk("rstreq mem_req_up", 32'(mem_bus.mem_req), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rstreq mem_req_drop", 32'(mem_bus.mem_req), 32'd0);
        chk("rstreq req_ready", 32'(core_bus.req_ready), 32'd1);
        mem_bus.mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_bus.mem_gnt = 1'b0;
        chk("rstreq idle_gnt_ignored", 32'(core_bus.resp_valid | mem_bus.mem_req), 32'd0);

        // Normal traffic after the aborted accesses
        e = model(1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h0000_7F00);
        run_access(1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h0000_7F00, 0, 0, o);
        check_access("post_rst", 1'b0, 32'h0000_0101, 0, 0, e, o);

`ifdef LSU_MEM_TIMEOUT_EN
        // No response at all: abort after 10 REQ/WAIT cycles
        run_access(1'b0, 3'b010, 32'h0000_D000, 32'h0, 32'h55AA_55AA, 0, -1, o);
        chk("to_none seen", 32'(o.got), 32'd1);
        chk("to_none err", 32'(o.err), 32'd1);
        chk("to_none cause", 32'(o.cause), 32'd3);
        chk("to_none rdata", o.rdata, 32'd0);
        chk("to_none latency", 32'(o.lat), 32'd12);
        // rvalid on the expiry cycle (10th REQ/WAIT cycle) completes normally
        run_access(1'b0, 3'b010, 32'h0000_D000, 32'h0, 32'h55AA_55AA, 0, 8, o);
        chk("to_edge seen", 32'(o.got), 32'd1);
        chk("to_edge err", 32'(o.err), 32'd0);
        chk("to_edge cause", 32'(o.cause), 32'd0);
        chk("to_edge rdata", o.rdata, 32'h55AA_55AA);
        chk("to_edge latency", 32'(o.lat), 32'd12);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store sequencer between the core's memory stage and a single word-wide data memory port.
- Accepts one load or store at a time and checks alignment.
- Drives word-aligned memory requests, with byte enables and lane-shifted store data for stores.
- Waits for the memory response. For loads, extracts and extends the addressed byte or halfword, then returns one registered response to the core.

Parameters:
- TIMEOUT_CYCLES, 255, cycles WAIT may last before the access is aborted (used only with the optional feature).
- TO_WIDTH, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data (0 for stores)
- resp_err  out  1  access faulted
- resp_cause  out  2  0 none, 1 misaligned, 2 illegal funct3, 3 timeout
- mem_req  out  1  memory request
- mem_gnt  in  1  memory accepted the request
- mem_we  out  1  write enable
- mem_addr  out  32  word address, req_addr with bits [1:0] forced to 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-shifted store data
- mem_rvalid  in  1  read data valid / write acknowledge
- mem_rdata  in  32  read word

Behaviour:
- Reset values:
  - state = IDLE, req_ready = 1.
  - resp_valid, resp_err, mem_req, mem_we = 0.
  - mem_be = 0, resp_cause = 0.
  - resp_rdata, mem_addr, mem_wdata = 0.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we, funct3, addr and wdata, and compute the fault.
  - Illegal funct3: loads 011, 110, 111; stores anything other than 000, 001, 010.
  - Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - On a fault, go to RESP with resp_err = 1 and no memory access. Illegal funct3 takes priority over misaligned.
  - Otherwise go to REQ.
- REQ:
  - mem_req = 1, with mem_addr, mem_we, mem_be and mem_wdata held stable until the cycle mem_gnt = 1, then go to WAIT.
  - mem_gnt is ignored outside REQ.
- WAIT:
  - mem_req = 0. On mem_rvalid, capture the extracted data and go to RESP.
  - mem_rvalid arriving in the same cycle as mem_gnt is not supported; memory responds at least one cycle after grant.
- RESP:
  - resp_valid = 1 for exactly one cycle, then return to IDLE.
  - resp_rdata, resp_err and resp_cause are held until the next response.
  - req_ready = 0 in REQ, WAIT and RESP, so there is no overlap. Minimum latency is 4 cycles from accept to resp_valid (accept, REQ+gnt, WAIT+rvalid, RESP).
- Byte enables by funct3:
  - byte: mem_be = 0001 << addr[1:0].
  - half: mem_be = 0011 << addr[1:0].
  - word: mem_be = 1111.
- Store data: mem_wdata = replicated or shifted so the byte/half sits in the addressed lane, i.e. wdata << (8*addr[1:0]) after masking to size.
- Load extraction: select lane by addr[1:0].
  - 000 sign-extends a byte, 001 sign-extends a half, 010 passes the word.
  - 100 zero-extends a byte, 101 zero-extends a half.
- Stores return resp_rdata = 0.
- Reset mid-operation drops any in-flight access: mem_req falls the next cycle and a late mem_rvalid in IDLE is ignored.

Optional Feature:
- Macro LSU_MEM_TIMEOUT_EN.
- When defined:
  - A TO_WIDTH counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES, go to RESP with resp_err = 1, cause = 3 and resp_rdata = 0.
  - A mem_rvalid in the same cycle as expiry wins (no error).
- When undefined: no counter; the controller waits indefinitely and cause 3 is never produced.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - state enum {IDLE, REQ, WAIT, RESP}.
  - cause constants.
- One sub-module, lsu_load_align: purely combinational (funct3, offset, word) -> extended data. The FSM, counter, byte-enable and store-shift logic stay in lsu_mem_ctrl.

Test Plan:
- LB, addr 0x1003, mem_rdata 0x80xxxxxx.
  - mem_addr 0x1000, mem_be 0000 (load), resp_rdata 0xFFFFFF80, resp_err 0.
  - resp_valid exactly 4 cycles after accept with gnt and rvalid on first opportunity.
- SH, addr 0x2002, wdata 0x0000BEEF → mem_be 1100, mem_wdata[31:16] = 0xBEEF, mem_we 1, resp_rdata 0.
- LHU, addr 0x3001 → no mem_req ever asserted, resp_err 1, cause 1, resp_valid 2 cycles after accept.
- Load with funct3 011 → cause 2. Hold mem_gnt low 5 cycles in REQ → mem_req and mem_addr stay stable throughout, req_ready stays 0.
- Reset asserted in WAIT, then mem_rvalid pulsed → no resp_valid; req_ready 1 the cycle after reset.
- With LSU_MEM_TIMEOUT_EN and TIMEOUT_CYCLES 10: never assert rvalid → resp_err 1, cause 3. Repeat with rvalid on the expiry cycle → resp_err 0.
